// File: rtl/temp_clasificador_multicanal_pkg.sv
// Shared definitions for the multichannel temperature classifier:
// class encoding, default band constants and the raw classification function.
package temp_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_LEVE   = 2'd1,
    CLS_GRAVE  = 2'd2
  } cls_t;

  localparam int DEF_N_CH        = 4;
  localparam int DEF_W           = 4;
  localparam int DEF_NORM_LO     = 8;
  localparam int DEF_NORM_HI     = 9;
  localparam int DEF_LEVE_MARGIN = 1;
  localparam int DEF_PERSIST     = 3;

  // Unsigned band compare. The lower LEVE test is written as t + margin >= lo
  // so a band that would start below zero simply clamps instead of wrapping.
  function automatic cls_t clasificar(input int unsigned t, input int unsigned lo,
                                      input int unsigned hi, input int unsigned margin);
    cls_t c;
    if (t >= lo && t <= hi)
      c = CLS_NORMAL;
    else if ((t < lo && (t + margin) >= lo) || (t > hi && t <= (hi + margin)))
      c = CLS_LEVE;
    else
      c = CLS_GRAVE;
    return c;
  endfunction

endpackage

// File: rtl/temp_clasificador_multicanal_if.sv
// Bus between the sensor front end (master) and the classifier (slave).
// Handshake: temp_valid[c] is a per-channel strobe with no back-pressure; a
// sample is consumed on every rising edge where its strobe is high.
// alarm_ack[c] is a level sampled on each rising edge.
interface temp_clasificador_multicanal_if #(
  parameter int N_CH = 4,
  parameter int W    = 4
);
  logic [N_CH*W-1:0] temp_in;
  logic [N_CH-1:0]   temp_valid;
  logic [N_CH-1:0]   alarm_ack;
  logic [N_CH-1:0]   temp_normal;
  logic [N_CH-1:0]   temp_leve;
  logic [N_CH-1:0]   temp_grave;
  logic [N_CH-1:0]   state_valid;
  logic [N_CH-1:0]   change_pulse;
  logic [N_CH-1:0]   alarm_latch;
  logic              any_grave;

  modport master (
    output temp_in, temp_valid, alarm_ack,
    input  temp_normal, temp_leve, temp_grave, state_valid,
           change_pulse, alarm_latch, any_grave
  );

  modport slave (
    input  temp_in, temp_valid, alarm_ack,
    output temp_normal, temp_leve, temp_grave, state_valid,
           change_pulse, alarm_latch, any_grave
  );
endinterface

// File: rtl/temp_clasificador_multicanal_filtro.sv
// One channel: raw classification, persistence filter and sticky GRAVE alarm.
module temp_canal_filtro
  import temp_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int NORM_LO     = DEF_NORM_LO,
  parameter int NORM_HI     = DEF_NORM_HI,
  parameter int LEVE_MARGIN = DEF_LEVE_MARGIN,
  parameter int PERSIST     = DEF_PERSIST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] temp,
  input  logic         valid,
  input  logic         ack,
  output logic         normal,
  output logic         leve,
  output logic         grave,
  output logic         state_valid,
  output logic         change_pulse,
  output logic         alarm_latch
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] P_MAX = CW'(PERSIST);

  cls_t          raw;
  cls_t          cand;
  cls_t          filt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n;
  logic          commit;
  logic          set_latch;
  logic          clr_latch;

  // Next persistence count and the commit / latch decisions for this sample.
  always_comb begin
    raw = clasificar(32'(temp), NORM_LO, NORM_HI, LEVE_MARGIN);
    if (raw == cand)
      n = (cnt >= P_MAX) ? P_MAX : cnt + 1'b1;
    else
      n = CW'(1);
    commit    = valid && (n == P_MAX) && ((raw != filt) || !state_valid);
    set_latch = commit && (raw == CLS_GRAVE);
    clr_latch = ack && (filt != CLS_GRAVE) && !set_latch;
  end

  // Candidate/count tracking, filtered class commit and alarm latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand         <= CLS_NORMAL;
      cnt          <= '0;
      filt         <= CLS_NORMAL;
      state_valid  <= 1'b0;
      change_pulse <= 1'b0;
      alarm_latch  <= 1'b0;
    end else begin
      change_pulse <= commit;
      if (valid) begin
        cand <= raw;
        cnt  <= n;
      end
      if (commit) begin
        filt        <= raw;
        state_valid <= 1'b1;
      end
      if (set_latch)
        alarm_latch <= 1'b1;
      else if (clr_latch)
        alarm_latch <= 1'b0;
    end
  end

  assign normal = state_valid && (filt == CLS_NORMAL);
  assign leve   = state_valid && (filt == CLS_LEVE);
  assign grave  = state_valid && (filt == CLS_GRAVE);

endmodule

// File: rtl/temp_clasificador_multicanal.sv
// Multichannel temperature classifier: N_CH independent filtered channels
// plus a registered aggregate GRAVE alarm for the supervisory logic.
module temp_clasificador_multicanal
  import temp_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int W           = DEF_W,
  parameter int NORM_LO     = DEF_NORM_LO,
  parameter int NORM_HI     = DEF_NORM_HI,
  parameter int LEVE_MARGIN = DEF_LEVE_MARGIN,
  parameter int PERSIST     = DEF_PERSIST
) (
  input logic clk,
  input logic rst_n,
  temp_clasificador_multicanal_if.slave bus
);

  if (NORM_HI < NORM_LO || NORM_HI > (2 ** W) - 1 || PERSIST < 1) begin : g_bad_params
    $error("temp_clasificador_multicanal: invalid band or persistence parameters");
  end

  logic [N_CH-1:0] normal_v;
  logic [N_CH-1:0] leve_v;
  logic [N_CH-1:0] grave_v;
  logic [N_CH-1:0] sv_v;
  logic [N_CH-1:0] pulse_v;
  logic [N_CH-1:0] latch_v;
  logic            any_grave_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    temp_canal_filtro #(
      .W(W), .NORM_LO(NORM_LO), .NORM_HI(NORM_HI),
      .LEVE_MARGIN(LEVE_MARGIN), .PERSIST(PERSIST)
    ) u_filtro (
      .clk          (clk),
      .rst_n        (rst_n),
      .temp         (bus.temp_in[c*W +: W]),
      .valid        (bus.temp_valid[c]),
      .ack          (bus.alarm_ack[c]),
      .normal       (normal_v[c]),
      .leve         (leve_v[c]),
      .grave        (grave_v[c]),
      .state_valid  (sv_v[c]),
      .change_pulse (pulse_v[c]),
      .alarm_latch  (latch_v[c])
    );
  end

  // Aggregate alarm, one cycle behind the per-channel latches.
  always_ff @(posedge clk) begin
    if (!rst_n) any_grave_q <= 1'b0;
    else        any_grave_q <= |latch_v;
  end

  assign bus.temp_normal  = normal_v;
  assign bus.temp_leve    = leve_v;
  assign bus.temp_grave   = grave_v;
  assign bus.state_valid  = sv_v;
  assign bus.change_pulse = pulse_v;
  assign bus.alarm_latch  = latch_v;
  assign bus.any_grave    = any_grave_q;

endmodule

// File: tb/tb_temp_clasificador_multicanal.sv
// Directed bench for temp_clasificador_multicanal using three configurations:
// legacy (1 channel, PERSIST=1), default (4 channels, PERSIST=3) and a wide
// 8-bit band configuration.
module tb_temp_clasificador_multicanal;

  localparam logic [2:0] E_N = 3'b100;
  localparam logic [2:0] E_L = 3'b010;
  localparam logic [2:0] E_G = 3'b001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  temp_clasificador_multicanal_if #(.N_CH(1), .W(4)) if_leg ();
  temp_clasificador_multicanal_if #(.N_CH(4), .W(4)) if_def ();
  temp_clasificador_multicanal_if #(.N_CH(4), .W(8)) if_str ();

  temp_clasificador_multicanal #(
    .N_CH(1), .W(4), .NORM_LO(8), .NORM_HI(9), .LEVE_MARGIN(1), .PERSIST(1)
  ) u_leg (.clk(clk), .rst_n(rst_n), .bus(if_leg));

  temp_clasificador_multicanal #(
    .N_CH(4), .W(4), .NORM_LO(8), .NORM_HI(9), .LEVE_MARGIN(1), .PERSIST(3)
  ) u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));

  temp_clasificador_multicanal #(
    .N_CH(4), .W(8), .NORM_LO(0), .NORM_HI(36), .LEVE_MARGIN(5), .PERSIST(1)
  ) u_str (.clk(clk), .rst_n(rst_n), .bus(if_str));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_leg.temp_in = '0; if_leg.temp_valid = '0; if_leg.alarm_ack = '0;
    if_def.temp_in = '0; if_def.temp_valid = '0; if_def.alarm_ack = '0;
    if_str.temp_in = '0; if_str.temp_valid = '0; if_str.alarm_ack = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({if_def.temp_normal, if_def.temp_leve, if_def.temp_grave, if_def.state_valid,
         if_def.change_pulse, if_def.alarm_latch, if_def.any_grave} !== 25'd0) begin
      bad++;
      $display("FAIL reset_def got n=%b l=%b g=%b sv=%b p=%b lat=%b any=%b exp all 0",
               if_def.temp_normal, if_def.temp_leve, if_def.temp_grave, if_def.state_valid,
               if_def.change_pulse, if_def.alarm_latch, if_def.any_grave);
    end
    total++;
    if ({if_leg.temp_normal, if_leg.temp_leve, if_leg.temp_grave, if_leg.state_valid,
         if_leg.change_pulse, if_leg.alarm_latch, if_leg.any_grave} !== 7'd0) begin
      bad++;
      $display("FAIL reset_leg got nonzero outputs exp all 0");
    end
    total++;
    if ({if_str.state_valid, if_str.alarm_latch, if_str.any_grave} !== 9'd0) begin
      bad++;
      $display("FAIL reset_str got sv=%b lat=%b any=%b exp 0", if_str.state_valid,
               if_str.alarm_latch, if_str.any_grave);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_legacy();
    logic [2:0] exp_cls;
    logic [2:0] prev_cls;
    logic [2:0] got;
    logic       exp_pulse;
    prev_cls = 3'b000;
    for (int code = 0; code < 16; code++) begin
      if_leg.temp_in = 4'(code);
      if_leg.temp_valid = 1'b1;
      tick();
      if (code == 8 || code == 9)       exp_cls = E_N;
      else if (code == 7 || code == 10) exp_cls = E_L;
      else                              exp_cls = E_G;
      exp_pulse = (exp_cls != prev_cls);
      prev_cls = exp_cls;
      got = {if_leg.temp_normal[0], if_leg.temp_leve[0], if_leg.temp_grave[0]};
      total++;
      if (got !== exp_cls || if_leg.state_valid[0] !== 1'b1) begin
        bad++;
        $display("FAIL legacy_class code=%0d got=%b sv=%b exp=%b sv=1", code, got,
                 if_leg.state_valid[0], exp_cls);
      end
      total++;
      if (if_leg.change_pulse[0] !== exp_pulse) begin
        bad++;
        $display("FAIL legacy_pulse code=%0d got=%b exp=%b", code,
                 if_leg.change_pulse[0], exp_pulse);
      end
    end
    if_leg.temp_valid = 1'b0;
  endtask

  task automatic test_persistence();
    logic [3:0] seq [4];
    seq[0] = 4'd9; seq[1] = 4'd12; seq[2] = 4'd12; seq[3] = 4'd9;
    do_reset();
    if_def.temp_in[3:0] = 4'd8;
    if_def.temp_valid[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (if_def.state_valid[0] !== 1'b0 || if_def.temp_normal[0] !== 1'b0) begin
        bad++;
        $display("FAIL persist_early i=%0d got sv=%b n=%b exp 0 0", i,
                 if_def.state_valid[0], if_def.temp_normal[0]);
      end
    end
    if_def.temp_valid[0] = 1'b0;
    repeat (5) tick();
    total++;
    if (if_def.state_valid[0] !== 1'b0 || if_def.change_pulse[0] !== 1'b0) begin
      bad++;
      $display("FAIL persist_gap got sv=%b p=%b exp 0 0", if_def.state_valid[0],
               if_def.change_pulse[0]);
    end
    if_def.temp_valid[0] = 1'b1;
    tick();
    total++;
    if ({if_def.state_valid[0], if_def.temp_normal[0], if_def.temp_leve[0],
         if_def.temp_grave[0], if_def.change_pulse[0]} !== 5'b11001) begin
      bad++;
      $display("FAIL persist_commit got sv,n,l,g,p=%b%b%b%b%b exp 11001",
               if_def.state_valid[0], if_def.temp_normal[0], if_def.temp_leve[0],
               if_def.temp_grave[0], if_def.change_pulse[0]);
    end
    if_def.temp_valid[0] = 1'b0;
    tick();
    total++;
    if (if_def.change_pulse[0] !== 1'b0 || if_def.temp_normal[0] !== 1'b1) begin
      bad++;
      $display("FAIL persist_pulse_width got p=%b n=%b exp p=0 n=1",
               if_def.change_pulse[0], if_def.temp_normal[0]);
    end
    for (int i = 0; i < 4; i++) begin
      if_def.temp_in[3:0] = seq[i];
      if_def.temp_valid[0] = 1'b1;
      tick();
      total++;
      if ({if_def.temp_normal[0], if_def.temp_leve[0], if_def.temp_grave[0]} !== E_N ||
          if_def.change_pulse[0] !== 1'b0) begin
        bad++;
        $display("FAIL persist_restart i=%0d got cls=%b%b%b p=%b exp 100 p=0", i,
                 if_def.temp_normal[0], if_def.temp_leve[0], if_def.temp_grave[0],
                 if_def.change_pulse[0]);
      end
    end
    if_def.temp_valid[0] = 1'b0;
  endtask

  task automatic test_alarm_latch();
    if_def.temp_in[7:4] = 4'd3;
    if_def.temp_valid[1] = 1'b1;
    repeat (3) tick();
    if_def.temp_valid[1] = 1'b0;
    total++;
    if (if_def.temp_grave[1] !== 1'b1 || if_def.alarm_latch[1] !== 1'b1 ||
        if_def.any_grave !== 1'b0) begin
      bad++;
      $display("FAIL latch_set got g=%b lat=%b any=%b exp 1 1 0", if_def.temp_grave[1],
               if_def.alarm_latch[1], if_def.any_grave);
    end
    tick();
    total++;
    if (if_def.any_grave !== 1'b1) begin
      bad++;
      $display("FAIL any_grave_rise got=%b exp=1", if_def.any_grave);
    end
    if_def.alarm_ack[1] = 1'b1;
    tick();
    if_def.alarm_ack[1] = 1'b0;
    total++;
    if (if_def.alarm_latch[1] !== 1'b1) begin
      bad++;
      $display("FAIL ack_while_grave got lat=%b exp=1", if_def.alarm_latch[1]);
    end
    if_def.temp_in[7:4] = 4'd8;
    if_def.temp_valid[1] = 1'b1;
    repeat (3) tick();
    if_def.temp_valid[1] = 1'b0;
    total++;
    if (if_def.temp_normal[1] !== 1'b1 || if_def.alarm_latch[1] !== 1'b1 ||
        if_def.change_pulse[1] !== 1'b1) begin
      bad++;
      $display("FAIL back_to_normal got n=%b lat=%b p=%b exp 1 1 1", if_def.temp_normal[1],
               if_def.alarm_latch[1], if_def.change_pulse[1]);
    end
    if_def.alarm_ack[1] = 1'b1;
    tick();
    if_def.alarm_ack[1] = 1'b0;
    total++;
    if (if_def.alarm_latch[1] !== 1'b0 || if_def.any_grave !== 1'b1) begin
      bad++;
      $display("FAIL ack_clear got lat=%b any=%b exp 0 1", if_def.alarm_latch[1],
               if_def.any_grave);
    end
    tick();
    total++;
    if (if_def.any_grave !== 1'b0) begin
      bad++;
      $display("FAIL any_grave_fall got=%b exp=0", if_def.any_grave);
    end
    total++;
    if (if_def.temp_normal[0] !== 1'b1 || if_def.alarm_latch[0] !== 1'b0) begin
      bad++;
      $display("FAIL ch0_isolation got n=%b lat=%b exp 1 0", if_def.temp_normal[0],
               if_def.alarm_latch[0]);
    end
  endtask

  task automatic test_collision();
    if_def.temp_in[11:8] = 4'd0;
    if_def.temp_valid[2] = 1'b1;
    if_def.alarm_ack[2] = 1'b1;
    repeat (3) tick();
    if_def.temp_valid[2] = 1'b0;
    if_def.alarm_ack[2] = 1'b0;
    total++;
    if (if_def.alarm_latch[2] !== 1'b1 || if_def.temp_grave[2] !== 1'b1) begin
      bad++;
      $display("FAIL set_ack_collision got lat=%b g=%b exp 1 1", if_def.alarm_latch[2],
               if_def.temp_grave[2]);
    end
  endtask

  task automatic test_mid_reset();
    if_def.temp_in[15:12] = 4'd7;
    if_def.temp_valid[3] = 1'b1;
    repeat (2) tick();
    if_def.temp_valid[3] = 1'b0;
    total++;
    if (if_def.state_valid[3] !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_partial got sv=%b exp=0", if_def.state_valid[3]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({if_def.temp_normal, if_def.temp_leve, if_def.temp_grave, if_def.state_valid,
         if_def.change_pulse, if_def.alarm_latch, if_def.any_grave} !== 25'd0) begin
      bad++;
      $display("FAIL mid_reset got n=%b l=%b g=%b sv=%b p=%b lat=%b any=%b exp all 0",
               if_def.temp_normal, if_def.temp_leve, if_def.temp_grave, if_def.state_valid,
               if_def.change_pulse, if_def.alarm_latch, if_def.any_grave);
    end
    if_def.temp_valid[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (if_def.state_valid[3] !== (i == 2) ||
          if_def.temp_leve[3] !== (i == 2)) begin
        bad++;
        $display("FAIL post_reset_count i=%0d got sv=%b l=%b exp %0d", i,
                 if_def.state_valid[3], if_def.temp_leve[3], (i == 2));
      end
    end
    if_def.temp_valid[3] = 1'b0;
  endtask

  task automatic test_param_stress();
    logic [7:0] codes [5][4];
    logic [2:0] expc  [5][4];
    logic [3:0] vmask [5];
    logic [2:0] prev  [4];
    logic [2:0] got;
    logic       exp_pulse;
    codes[0] = '{8'd0,   8'd37, 8'd42, 8'd255};
    expc[0]  = '{E_N,    E_L,   E_G,   E_G};
    codes[1] = '{8'd36,  8'd41, 8'd1,  8'd40};
    expc[1]  = '{E_N,    E_L,   E_N,   E_L};
    codes[2] = '{8'd42,  8'd0,  8'd38, 8'd36};
    expc[2]  = '{E_G,    E_N,   E_L,   E_N};
    codes[3] = '{8'd255, 8'd36, 8'd41, 8'd0};
    expc[3]  = '{E_G,    E_N,   E_L,   E_N};
    codes[4] = '{8'd5,   8'd255, 8'd200, 8'd100};
    expc[4]  = '{E_G,    E_G,   E_L,   E_N};
    vmask[0] = 4'b1111; vmask[1] = 4'b1111; vmask[2] = 4'b1111;
    vmask[3] = 4'b1111; vmask[4] = 4'b0010;
    for (int c = 0; c < 4; c++) prev[c] = 3'b000;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) if_str.temp_in[c*8 +: 8] = codes[k][c];
      if_str.temp_valid = vmask[k];
      tick();
      for (int c = 0; c < 4; c++) begin
        got = {if_str.temp_normal[c], if_str.temp_leve[c], if_str.temp_grave[c]};
        exp_pulse = vmask[k][c] && (expc[k][c] != prev[c]);
        prev[c] = expc[k][c];
        total++;
        if (got !== expc[k][c] || if_str.change_pulse[c] !== exp_pulse) begin
          bad++;
          $display("FAIL stress k=%0d ch=%0d code=%0d got cls=%b p=%b exp cls=%b p=%b",
                   k, c, codes[k][c], got, if_str.change_pulse[c], expc[k][c], exp_pulse);
        end
      end
    end
    if_str.temp_valid = '0;
    total++;
    if (if_str.alarm_latch !== 4'b1111 || if_str.any_grave !== 1'b1) begin
      bad++;
      $display("FAIL stress_alarm got lat=%b any=%b exp 1111 1", if_str.alarm_latch,
               if_str.any_grave);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_legacy();
    test_persistence();
    test_alarm_latch();
    test_collision();
    test_mid_reset();
    test_param_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
